digital_clock_hms: RTL and testbench
====================================

// Module: digital_clock_hms
// PURPOSE
//  Parametrised HH:MM:SS time-of-day counter with 12/24-h display mode, synchronous time-set and minute-resolution alarm.
//  Single-clock design: all timing derives from a 1-Hz clock-enable tick, with no generated or divided clocks.
//  Sits between the board oscillator and the display/LED drivers of the lab clock designs.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency; prescaler divisor (5 for simulation)
//  CNT_W       26          prescaler width; must satisfy 2**CNT_W >= CLK_HZ
//  HOURS_24    1           reset value of the internal mode flag (1 = 24-h, 0 = 12-h); overridden by mode_12h
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  run        in   1  1 = time advances; 0 = prescaler and time frozen (hold, not clear)
//  set_en     in   1  1-cycle strobe: load set_hh/set_mm/set_ss
//  set_hh     in   5  load value, hours 0..23 (always 24-h encoding)
//  set_mm     in   6  load value, minutes 0..59
//  set_ss     in   6  load value, seconds 0..59
//  mode_12h   in   1  display select: 1 = 12-h (hr 1..12 + pm), 0 = 24-h
//  alarm_en   in   1  alarm arm
//  alarm_hh   in   5  alarm hour 0..23
//  alarm_mm   in   6  alarm minute 0..59
//  sec        out  6  seconds 0..59
//  min        out  6  minutes 0..59
//  hr         out  5  hours: 0..23 (24-h) or 1..12 (12-h)
//  pm         out  1  1 when internal hour >= 12 (valid in both modes)
//  tick_1hz   out  1  1-cycle pulse each second advance
//  alarm_hit  out  1  1-cycle pulse on alarm match
// BEHAVIOUR
//  Reset (async, rst_n=0): prescaler=0, sec=min=0, internal hour=0, tick_1hz=0, alarm_hit=0; hr=0 in 24-h, 12 in 12-h; pm=0.
//  Prescaler: counts 0..CLK_HZ-1 while run=1. On the edge where count==CLK_HZ-1:
//   count<=0, tick_1hz<=1, sec advances on that same edge. Spacing is exactly CLK_HZ cycles.
//  Carry chain, all on the same edge:
//   sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
//   23:59:59 -> 00:00:00 in one edge.
//  run=0: count, sec, min and hour hold; tick_1hz=0. Resuming continues from the held count, with no restart.
//  set_en=1 has priority over the tick and over run:
//   fields load next edge; prescaler clears to 0; tick_1hz=0 that cycle.
//   First tick after a set occurs CLK_HZ cycles later (if run=1).
//   Out-of-range fields (hh>23, mm/ss>59) load as 0, per field independently.
//  Display mapping is combinational from registered hour; mode_12h may change at any time and affects outputs immediately:
//   12-h: hour 0 -> 12 AM, 1..11 -> 1..11 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
//  Alarm: alarm_hit<=1 for one cycle on the edge where a tick, not a set, makes time == alarm_hh:alarm_mm:00 and alarm_en=1.
//   A set landing on the alarm time does not fire.
//   Re-arming is automatic; the alarm fires again 24 h later.
//  Reset mid-count: everything returns to reset values immediately. A pending tick is lost.
// STRUCTURE
//  Shared package (clk_pkg): SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23 and field widths 6/6/5.
//  Sub-module mod_counter #(W, MAX):
//   inputs inc, load, load_val; outputs q, carry;
//   carry = inc & (q==MAX); out-of-range load -> 0.
//  Instantiated three times (sec/min/hour), chained carry -> inc.
//  Top level holds the prescaler, 12/24 mapping and alarm comparator.
// TESTING (CLK_HZ=5)
//  Reset, run=1, 20 clks -> tick_1hz pulses at clks 5,10,15,20; sec=4; min=0.
//  set 23:59:58, run=1 -> after 2 ticks time=00:00:00; hr=0 (24-h), hr=12, pm=0 (12-h).
//  set 13:05:00, toggle mode_12h -> hr 13 / pm=1 then hr=1 / pm=1 with no clock edge required.
//  run=0 for 7 clks mid-count (count=3) -> no tick, sec held; run=1 -> tick after 2 more clks.
//  alarm 00:01, alarm_en=1, set 00:00:59 -> alarm_hit single pulse with tick at 00:01:00; set 00:01:00 directly -> no pulse.
//  set_en with hh=24, mm=60, ss=61 -> 00:00:00; rst_n low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared field widths, limits and the time-of-day record for the HH:MM:SS clock.
// No logic state here; hour_12 is the combinational 24-h to 12-h display mapping.
package clk_pkg;

    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef struct packed {
        logic [HOUR_W-1:0] hh;
        logic [MIN_W-1:0]  mm;
        logic [SEC_W-1:0]  ss;
    } hms_t;

    // Hour 0 reads as 12 AM and 12 as 12 PM; pm is derived separately.
    function automatic logic [HOUR_W-1:0] hour_12(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] r;
        r = h;
        if (h == '0)
            r = HOUR_W'(12);
        else if (h > HOUR_W'(12))
            r = h - HOUR_W'(12);
        return r;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; out-of-range load values load as 0.
// Latency: q updates on the edge after inc/load; carry is combinational (inc & q==MAX).
// Backpressure: none; load has priority over inc.
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= (load_val > MAX_V) ? '0 : load_val;
        end else if (inc) begin
            q <= (q == MAX_V) ? '0 : q + 1'b1;
        end
    end

    assign carry = inc & (q == MAX_V);

endmodule

// File: rtl/digital_clock_hms.sv
// HH:MM:SS time-of-day counter driven by a 1-Hz enable from a CLK_HZ prescaler, with time-set and alarm.
// Latency: time, tick_1hz and alarm_hit update on the prescaler wrap edge; hr/pm are combinational.
// Backpressure: none; set_en overrides run and the tick, run=0 freezes prescaler and time.
module digital_clock_hms
    import clk_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int CNT_W    = 26,
    parameter int HOURS_24 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hh,
    input  logic [MIN_W-1:0]  set_mm,
    input  logic [SEC_W-1:0]  set_ss,
    input  logic              mode_12h,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hh,
    input  logic [MIN_W-1:0]  alarm_mm,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hr,
    output logic              pm,
    output logic              tick_1hz,
    output logic              alarm_hit
);

    if ((64'd1 << CNT_W) < 64'(CLK_HZ)) begin : g_bad_cnt_w
        $error("digital_clock_hms: CNT_W too narrow for CLK_HZ");
    end
    if ((HOURS_24 != 0) && (HOURS_24 != 1)) begin : g_bad_mode
        $error("digital_clock_hms: HOURS_24 must be 0 or 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick_now;
    logic             alarm_now;
    logic             sec_carry;
    logic             min_carry;
    logic             hour_carry;
    hms_t             now;
    logic [MIN_W-1:0]  next_mm;
    logic [HOUR_W-1:0] next_hh;

    // A set cycle never ticks, so the counters see either a load or an inc, not both.
    assign tick_now = run & ~set_en & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tick_1hz  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            tick_1hz  <= tick_now;
            alarm_hit <= alarm_now;
            if (set_en)
                cnt <= '0;
            else if (run)
                cnt <= tick_now ? '0 : cnt + 1'b1;
        end
    end

    mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (tick_now),
        .load     (set_en),
        .load_val (set_ss),
        .q        (now.ss),
        .carry    (sec_carry)
    );

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sec_carry),
        .load     (set_en),
        .load_val (set_mm),
        .q        (now.mm),
        .carry    (min_carry)
    );

    mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (min_carry),
        .load     (set_en),
        .load_val (set_hh),
        .q        (now.hh),
        .carry    (hour_carry)
    );

    // Alarm compares the time this tick is about to produce; only a seconds wrap can land on :00.
    assign next_mm   = min_carry ? '0 : now.mm + 1'b1;
    assign next_hh   = hour_carry ? '0 : (min_carry ? now.hh + 1'b1 : now.hh);
    assign alarm_now = sec_carry & alarm_en & (next_hh == alarm_hh) & (next_mm == alarm_mm);

    assign sec = now.ss;
    assign min = now.mm;
    assign hr  = mode_12h ? hour_12(now.hh) : now.hh;
    assign pm  = (now.hh >= HOUR_W'(12));

endmodule

// File: tb/tb_digital_clock_hms.sv
// Directed bench: stimulus pushes expected tick/alarm events into a scoreboard, a negedge monitor pops and compares.
module tb_digital_clock_hms;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       set_en;
    logic [4:0] set_hh;
    logic [5:0] set_mm;
    logic [5:0] set_ss;
    logic       mode_12h;
    logic       alarm_en;
    logic [4:0] alarm_hh;
    logic [5:0] alarm_mm;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       pm;
    logic       tick_1hz;
    logic       alarm_hit;

    typedef struct packed {
        logic [31:0] when;
        logic [5:0]  s;
        logic [5:0]  m;
        logic [4:0]  h;
        logic        p;
        logic        t;
        logic        a;
    } ev_t;

    ev_t sb[$];
    ev_t got;
    ev_t want;
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;
    int  c;

    digital_clock_hms #(.CLK_HZ(5), .CNT_W(3), .HOURS_24(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .set_en    (set_en),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
        .mode_12h  (mode_12h),
        .alarm_en  (alarm_en),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .sec       (sec),
        .min       (min),
        .hr        (hr),
        .pm        (pm),
        .tick_1hz  (tick_1hz),
        .alarm_hit (alarm_hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tick or alarm pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (tick_1hz === 1'b1 || alarm_hit === 1'b1)) begin
            checks++;
            got = '{when: cyc, s: sec, m: min, h: hr, p: pm, t: tick_1hz, a: alarm_hit};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got cyc=%0d %0d:%0d:%0d tick=%0b alarm=%0b, required no event",
                         cyc, hr, min, sec, tick_1hz, alarm_hit);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d %0d:%0d:%0d pm=%0b tick=%0b alarm=%0b, required cyc=%0d %0d:%0d:%0d pm=%0b tick=%0b alarm=%0b",
                             got.when, got.h, got.m, got.s, got.p, got.t, got.a,
                             want.when, want.h, want.m, want.s, want.p, want.t, want.a);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int when, input int h, input int m, input int s, input bit p, input bit a);
        ev_t e;
        e = '{when: when, s: 6'(s), m: 6'(m), h: 5'(h), p: p, t: 1'b1, a: a};
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_en = 1'b1;
        set_hh = 5'(h);
        set_mm = 6'(m);
        set_ss = 6'(s);
        step(1);
        set_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; set_en = 1'b0;
        set_hh = '0; set_mm = '0; set_ss = '0;
        mode_12h = 1'b0; alarm_en = 1'b0; alarm_hh = '0; alarm_mm = '0;

        // Reset state in both display modes
        step(2);
        chk("rst_sec", sec, 0);
        chk("rst_min", min, 0);
        chk("rst_hr24", hr, 0);
        chk("rst_pm", pm, 0);
        chk("rst_tick", tick_1hz, 0);
        chk("rst_alarm", alarm_hit, 0);
        mode_12h = 1'b1; #1;
        chk("rst_hr12", hr, 12);
        mode_12h = 1'b0;

        // Free run: ticks every 5 clocks
        rst_n = 1'b1; run = 1'b1; c = cyc;
        for (int i = 1; i <= 4; i++) push(c + 5 * i, 0, 0, i, 1'b0, 1'b0);
        step(20);
        chk("run20_sec", sec, 4);
        chk("run20_min", min, 0);
        run = 1'b0;

        // Full carry 23:59:59 -> 00:00:00
        do_set(23, 59, 58);
        run = 1'b1; c = cyc;
        push(c + 5, 23, 59, 59, 1'b1, 1'b0);
        push(c + 10, 0, 0, 0, 1'b0, 1'b0);
        step(10);
        run = 1'b0;
        chk("wrap_hr24", hr, 0);
        chk("wrap_pm24", pm, 0);
        mode_12h = 1'b1; #1;
        chk("wrap_hr12", hr, 12);
        chk("wrap_pm12", pm, 0);
        mode_12h = 1'b0;

        // Display mapping is combinational
        do_set(13, 5, 0);
        chk("h13_hr24", hr, 13);
        chk("h13_pm24", pm, 1);
        mode_12h = 1'b1; #1;
        chk("h13_hr12", hr, 1);
        chk("h13_pm12", pm, 1);
        do_set(12, 0, 0);
        chk("h12_hr12", hr, 12);
        chk("h12_pm12", pm, 1);
        do_set(11, 0, 0);
        chk("h11_hr12", hr, 11);
        chk("h11_pm12", pm, 0);
        mode_12h = 1'b0;

        // Hold mid-count: prescaler keeps its value
        do_set(0, 0, 10);
        run = 1'b1;
        step(3);
        run = 1'b0;
        step(7);
        chk("hold_sec", sec, 10);
        run = 1'b1; c = cyc;
        push(c + 2, 0, 0, 11, 1'b0, 1'b0);
        step(2);
        run = 1'b0;

        // Alarm fires with the tick, not on a set
        alarm_hh = 5'd0; alarm_mm = 6'd1; alarm_en = 1'b1;
        do_set(0, 0, 59);
        run = 1'b1; c = cyc;
        push(c + 5, 0, 1, 0, 1'b0, 1'b1);
        step(6);
        chk("alarm_one_cycle", alarm_hit, 0);
        run = 1'b0;
        do_set(0, 1, 0);
        step(2);
        chk("alarm_on_set", alarm_hit, 0);

        // Out-of-range loads clear per field
        do_set(24, 30, 61);
        chk("oor_hr", hr, 0);
        chk("oor_min", min, 30);
        chk("oor_sec", sec, 0);
        do_set(5, 60, 7);
        chk("oor2_hr", hr, 5);
        chk("oor2_min", min, 0);
        chk("oor2_sec", sec, 7);

        // Asynchronous reset mid-count
        do_set(3, 4, 5);
        run = 1'b1;
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sec", sec, 0);
        chk("arst_min", min, 0);
        chk("arst_hr", hr, 0);
        chk("arst_tick", tick_1hz, 0);
        step(1);
        run = 1'b0; rst_n = 1'b1;
        step(6);
        chk("arst_no_tick_sec", sec, 0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
